din_debounce_sync: RTL and testbench
====================================

// Module: din_debounce_sync
// PURPOSE
//  Conditions a raw asynchronous 1-bit input before it reaches the sync-reset D flip-flop stage.
//  Sits directly upstream of that stage and drives its din.
//  Synchronises the input through an N-flop chain, then requires DEBOUNCE_CYCLES consecutive
//  agreeing samples before the output changes. Emits one-cycle rise/fall pulses on each accepted edge.
// PARAMETERS
//  SYNC_STAGES      2  synchroniser depth; legal range >=2
//  DEBOUNCE_CYCLES  4  consecutive agreeing synced samples needed to accept a change; legal range >=2
//  CNT_W            8  qualify-counter width; DEBOUNCE_CYCLES must be < 2**CNT_W
// PORTS
//  clk   input   1  rising-edge clock
//  rst   input   1  asynchronous, active-high reset
//  din   input   1  raw asynchronous input
//  q     output  1  debounced, registered level; feeds the downstream DFF din
//  rise  output  1  one-cycle pulse, same cycle q goes 0->1
//  fall  output  1  one-cycle pulse, same cycle q goes 1->0
// BEHAVIOUR
//  - Reset: one clock; rst is asynchronous and active-high. rst=1 immediately clears the following:
//    sync chain=0, state=STABLE, cnt=0, q=0, rise=0, fall=0. rst dominates every other event.
//    Reset mid-qualify aborts the qualify. There is no pulse on reset release.
//  - Sync chain: s[0]<=din, s[i]<=s[i-1]. The synced value sy = s[SYNC_STAGES-1].
//  - FSM states STABLE and QUALIFY, all registered:
//    * STABLE, sy==q: hold, cnt=0.
//    * STABLE, sy!=q: go to QUALIFY, cnt<=1.
//    * QUALIFY, sy==q (bounce): abort to STABLE, cnt<=0, q unchanged, no pulse.
//    * QUALIFY, sy!=q, cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
//    * QUALIFY, sy!=q, cnt==DEBOUNCE_CYCLES-1: q<=sy, rise<=sy, fall<=~sy, go to STABLE, cnt<=0.
//  - rise and fall are high for exactly one cycle. They are never both high.
//    Both are low in every cycle in which q does not change.
//  - Latency: q changes at clock edge SYNC_STAGES+DEBOUNCE_CYCLES, counted from the first edge
//    that samples a stable new din. Defaults give 6 edges.
//  - Glitch filtering: a din pulse shorter than DEBOUNCE_CYCLES cycles, as seen at sy, never reaches q.
//  - The counter never wraps: cnt is bounded by DEBOUNCE_CYCLES-1 < 2**CNT_W.
//  - A din level that differs from q at reset release is qualified as a normal change.
// CONFIGURATION
//  Macro DEBOUNCE_GLITCH_CNT_EN:
//  - Defined: adds output glitch_cnt [7:0].
//    * Reset value 0.
//    * Increments by 1 on each QUALIFY->STABLE abort.
//    * Saturates at 255; never wraps.
//    * Accepted edges do not count.
//  - Undefined: no glitch_cnt port and no counter logic. All other behaviour is identical.
// TESTING (clk period 10, defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1. Reset with din=1, rst=1 for 10 -> q=0, rise=0, fall=0 during reset.
//     Release rst -> q=1 at the 6th edge after release, with rise=1 for exactly 1 cycle.
//  2. Clean edge: q=0, din 0->1 held 100 -> q=1 exactly 6 edges later; rise pulses 1 cycle; fall stays 0.
//  3. Glitch: q=0, din=1 for 2 cycles then 0 -> q stays 0, no pulses.
//     With DEBOUNCE_GLITCH_CNT_EN defined, glitch_cnt=1.
//  4. Bounce train: din toggles every 2 cycles for 40, then settles at 1 ->
//     q rises once, 6 edges after settling; a single rise pulse.
//  5. Async reset mid-qualify: raise rst between clock edges while cnt=2 ->
//     q, cnt, rise, fall clear before the next edge; no pulse afterwards.
//  6. Falling edge: q=1, din 1->0 held -> q=0 after 6 edges, fall=1 for 1 cycle.
//     With the macro defined, 300 glitches -> glitch_cnt=255.

Source files
------------

// File: rtl/din_debounce_sync.sv
// din_debounce_sync: conditions a raw asynchronous 1-bit input for the downstream
// sync-reset D flip-flop stage.
//
// The input passes through a SYNC_STAGES-deep synchroniser. The registered output q
// changes only after DEBOUNCE_CYCLES consecutive synced samples all differ from q.
// Each accepted change produces a one-cycle rise or fall pulse in the same cycle
// that q changes.
//
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to add an 8-bit saturating
// glitch_cnt output. It counts qualify attempts that were aborted by a bounce.
// Accepted edges are not counted.
//
// Reset is asynchronous and active-high. It clears the synchroniser, the FSM, the
// qualify counter, q and both pulses. It dominates every other event.
module din_debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       q,
  output logic       rise,
  output logic       fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  // STABLE: q agrees with the synced input.
  // QUALIFY: counting consecutive disagreeing samples.
  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  // Counter value on the sample that accepts the change. A bound of
  // DEBOUNCE_CYCLES-1 keeps the counter from ever wrapping.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] s;
  logic                   sy;

  state_t                 state;
  state_t                 state_n;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_n;
  logic                   q_n;
  logic                   rise_n;
  logic                   fall_n;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                   abort;
`endif

  // Synchroniser chain: s[0] samples din and each later stage copies the one before.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], din};
    end
  end

  assign sy = s[SYNC_STAGES-1];

  // State register. It holds the FSM state, the qualify counter, the debounced
  // level and the edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // Next-state logic.
  // - Pulses default low, so they last exactly one cycle.
  // - Any agreeing sample seen during QUALIFY aborts the attempt without changing q.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    abort   = 1'b0;
`endif
    case (state)
      STABLE: begin
        cnt_n = '0;
        if (sy != q) begin
          state_n = QUALIFY;
          cnt_n   = CNT_ONE;
        end
      end
      QUALIFY: begin
        if (sy == q) begin
          state_n = STABLE;
          cnt_n   = '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
          abort   = 1'b1;
`endif
        end else if (cnt >= CNT_LAST) begin
          state_n = STABLE;
          cnt_n   = '0;
          q_n     = sy;
          rise_n  = sy;
          fall_n  = ~sy;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = STABLE;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // Glitch counter: counts aborted qualify attempts and saturates at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= 8'd0;
    end else if (abort && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_din_debounce_sync.sv
// Testbench for din_debounce_sync with default parameters.
// Expected rise/fall events (kind and clock-edge number) are queued when stimulus
// is applied. A monitor pops and compares them whenever the DUT pulses.
module tb_din_debounce_sync;

  logic       clk;
  logic       rst;
  logic       din;
  logic       q;
  logic       rise;
  logic       fall;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
  int         gBase;
`endif

  typedef struct {
    bit isRise;
    int cyc;
  } ev_t;

  ev_t expq[$];
  int  cyc;
  int  tests;
  int  fails;

  din_debounce_sync #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .q   (q),
    .rise(rise),
    .fall(fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  // Free-running clock with period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to timestamp expected and observed pulses.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive din. The caller is at #1 after a clock edge.
  // ev: 0 = no edge expected, 1 = rise expected, 2 = fall expected.
  // A queued event is due 6 edges after this call (2 sync + 4 debounce).
  // The task returns at #1 after the hold-th following edge.
  task automatic applyStimulus(input logic v, input int hold, input int ev);
    ev_t e;
    din = v;
    if (ev != 0) begin
      e.isRise = (ev == 1);
      e.cyc    = cyc + 6;
      expq.push_back(e);
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  // Monitor: checks every pulse against the scoreboard and flags overdue entries.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (!rst) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        checkOutput("missed_pulse", cyc, expq[0].cyc);
        void'(expq.pop_front());
      end
      if (rise && fall) begin
        checkOutput("both_pulses", 1, 0);
      end else if (rise || fall) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_pulse", rise ? 1 : 2, 0);
        end else begin
          e = expq.pop_front();
          checkOutput("pulse_kind", int'(rise), int'(e.isRise));
          checkOutput("pulse_cycle", cyc, e.cyc);
          checkOutput("pulse_q", int'(q), int'(e.isRise));
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    din   = 1'b1;

    // Test 1: reset with din=1. Outputs stay low during reset; after release,
    // the high input qualifies as a normal rise.
    #12;
    checkOutput("reset_q", int'(q), 0);
    checkOutput("reset_rise", int'(rise), 0);
    checkOutput("reset_fall", int'(fall), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checkOutput("reset_glitch_cnt", int'(glitch_cnt), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 12, 1);
    checkOutput("t1_q_high", int'(q), 1);

    // Test 6: clean falling edge.
    applyStimulus(1'b0, 12, 2);
    checkOutput("t6_q_low", int'(q), 0);

    // Test 2: clean rising edge, then fall back to 0.
    applyStimulus(1'b1, 12, 1);
    checkOutput("t2_q_high", int'(q), 1);
    applyStimulus(1'b0, 12, 2);
    checkOutput("t2_q_low", int'(q), 0);

    // Test 3: a two-cycle glitch never reaches q.
`ifdef DEBOUNCE_GLITCH_CNT_EN
    gBase = int'(glitch_cnt);
`endif
    applyStimulus(1'b1, 2, 0);
    applyStimulus(1'b0, 10, 0);
    checkOutput("t3_q_low", int'(q), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checkOutput("t3_glitch_cnt", int'(glitch_cnt), gBase + 1);
`endif

    // Test 4: din toggles every 2 cycles for 40 cycles, then settles high.
    // Exactly one rise is expected.
`ifdef DEBOUNCE_GLITCH_CNT_EN
    gBase = int'(glitch_cnt);
`endif
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2) == 0, 2, 0);
    end
    checkOutput("t4_q_during_bounce", int'(q), 0);
    applyStimulus(1'b1, 12, 1);
    checkOutput("t4_q_high", int'(q), 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checkOutput("t4_glitch_cnt", int'(glitch_cnt), gBase + 10);
`endif

    // Test 5: assert reset asynchronously while cnt=2 during a falling qualify.
    applyStimulus(1'b0, 4, 0);
    checkOutput("t5_cnt_before", int'(dut.cnt), 2);
    checkOutput("t5_q_before", int'(q), 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t5_q_async", int'(q), 0);
    checkOutput("t5_cnt_async", int'(dut.cnt), 0);
    checkOutput("t5_rise_async", int'(rise), 0);
    checkOutput("t5_fall_async", int'(fall), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 10, 0);
    checkOutput("t5_q_after", int'(q), 0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Test 6 (extended): 300 glitches saturate the glitch counter at 255.
    checkOutput("t6_glitch_cnt_cleared", int'(glitch_cnt), 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 2, 0);
      applyStimulus(1'b0, 3, 0);
    end
    checkOutput("t6_glitch_cnt_sat", int'(glitch_cnt), 255);
    checkOutput("t6_q_low", int'(q), 0);
`endif

    repeat (5) @(posedge clk);
    #1;
    checkOutput("pending_events", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
